// File: rtl/alsu_cmd_feeder.sv
// Command feeder for the ALSU: buffers packed commands, issues at most one per cycle
// onto the ALSU pins, and returns each result in order with its invalid-op flag.
module alsu_cmd_feeder #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    output logic        alsu_direction,
    input  logic [5:0]  alsu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_data,
    output logic        rsp_invalid,
    output logic [2:0]  inflight
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam logic [CPW:0]   CMD_FULL    = CMD_DEPTH[CPW:0];
    localparam logic [RPW+1:0] RSP_CREDITS = RSP_DEPTH[RPW+1:0];

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] opcode;
        logic       cin;
        logic       serial_in;
        logic       red_op_a;
        logic       red_op_b;
        logic       bypass_a;
        logic       bypass_b;
        logic       direction;
    } cmd_t;

    typedef struct packed {
        logic       invalid;
        logic [5:0] data;
    } rsp_t;

    cmd_t           cmd_mem_q [CMD_DEPTH];
    cmd_t           cmd_mem_d [CMD_DEPTH];
    logic [CPW-1:0] cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CPW:0]   cmd_cnt_q, cmd_cnt_d;

    cmd_t           pins_q, pins_d;
    logic [LAT:0]   vld_pipe_q, vld_pipe_d;
    logic [LAT:0]   inv_pipe_q, inv_pipe_d;

    rsp_t           rsp_mem_q [RSP_DEPTH];
    rsp_t           rsp_mem_d [RSP_DEPTH];
    logic [RPW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
    logic [RPW:0]   rsp_cnt_q, rsp_cnt_d;
    logic [RPW:0]   inflight_q, inflight_d;

    cmd_t           head;
    logic           head_invalid;
    logic           cmd_push;
    logic           issue;
    logic           rsp_push;
    logic           rsp_pop;
    logic [RPW+1:0] credits_used;

    // Handshakes and issue decision
    always_comb begin
        cmd_ready    = rst & (cmd_cnt_q < CMD_FULL);
        cmd_push     = cmd_valid & cmd_ready;
        head         = cmd_mem_q[cmd_rd_q];
        // Outstanding work plus buffered results may never exceed the response FIFO
        credits_used = {1'b0, inflight_q} + {1'b0, rsp_cnt_q};
        issue        = (cmd_cnt_q != '0) && (credits_used < RSP_CREDITS);
        head_invalid = ((head.red_op_a | head.red_op_b) & (head.opcode[1] | head.opcode[2]))
                     | (head.opcode[1] & head.opcode[2]);
        rsp_push     = vld_pipe_q[LAT];
        rsp_valid    = (rsp_cnt_q != '0);
        rsp_pop      = rsp_valid & rsp_ready;
    end

    // Command FIFO
    always_comb begin
        cmd_mem_d = cmd_mem_q;
        cmd_wr_d  = cmd_wr_q;
        cmd_rd_d  = cmd_rd_q;
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_push) begin
            cmd_mem_d[cmd_wr_q] = cmd_t'(cmd_data);
            cmd_wr_d            = cmd_wr_q + 1'b1;
        end
        if (issue) begin
            cmd_rd_d = cmd_rd_q + 1'b1;
        end
        case ({cmd_push, issue})
            2'b10:   cmd_cnt_d = cmd_cnt_q + 1'b1;
            2'b01:   cmd_cnt_d = cmd_cnt_q - 1'b1;
            default: cmd_cnt_d = cmd_cnt_q;
        endcase
    end

    // Pin drive and latency tracking; idle slots drive the all-zero NOP
    always_comb begin
        pins_d     = issue ? head : cmd_t'('0);
        vld_pipe_d = {vld_pipe_q[LAT-1:0], issue};
        inv_pipe_d = {inv_pipe_q[LAT-1:0], issue & head_invalid};
        case ({issue, rsp_push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Response FIFO
    always_comb begin
        rsp_mem_d = rsp_mem_q;
        rsp_wr_d  = rsp_wr_q;
        rsp_rd_d  = rsp_rd_q;
        rsp_cnt_d = rsp_cnt_q;
        if (rsp_push) begin
            rsp_mem_d[rsp_wr_q] = '{invalid: inv_pipe_q[LAT], data: alsu_out};
            rsp_wr_d            = rsp_wr_q + 1'b1;
        end
        if (rsp_pop) begin
            rsp_rd_d = rsp_rd_q + 1'b1;
        end
        case ({rsp_push, rsp_pop})
            2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
            2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
            default: rsp_cnt_d = rsp_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_mem_q  <= '{default: '0};
            cmd_wr_q   <= '0;
            cmd_rd_q   <= '0;
            cmd_cnt_q  <= '0;
            pins_q     <= '0;
            vld_pipe_q <= '0;
            inv_pipe_q <= '0;
            rsp_mem_q  <= '{default: '0};
            rsp_wr_q   <= '0;
            rsp_rd_q   <= '0;
            rsp_cnt_q  <= '0;
            inflight_q <= '0;
        end else begin
            cmd_mem_q  <= cmd_mem_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_rd_q   <= cmd_rd_d;
            cmd_cnt_q  <= cmd_cnt_d;
            pins_q     <= pins_d;
            vld_pipe_q <= vld_pipe_d;
            inv_pipe_q <= inv_pipe_d;
            rsp_mem_q  <= rsp_mem_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_cnt_q  <= rsp_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    assign alsu_A         = pins_q.a;
    assign alsu_B         = pins_q.b;
    assign alsu_opcode    = pins_q.opcode;
    assign alsu_cin       = pins_q.cin;
    assign alsu_serial_in = pins_q.serial_in;
    assign alsu_red_op_A  = pins_q.red_op_a;
    assign alsu_red_op_B  = pins_q.red_op_b;
    assign alsu_bypass_A  = pins_q.bypass_a;
    assign alsu_bypass_B  = pins_q.bypass_b;
    assign alsu_direction = pins_q.direction;

    // An empty FIFO presents zeros rather than a stale entry
    assign rsp_data    = rsp_valid ? rsp_mem_q[rsp_rd_q].data : 6'd0;
    assign rsp_invalid = rsp_valid & rsp_mem_q[rsp_rd_q].invalid;
    assign inflight    = 3'(inflight_q);

endmodule
